// File: rtl/if_id_ir_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_id_ir_stage_pkg
//
// Shared definitions for the registered IF/ID instruction stage:
//   - NOP_WORD_DEFAULT : default bubble word injected into ID
//   - REM_W            : width of the post-branch bubble down-counter
//   - state_e          : bubble-drain FSM encoding (RUN / DRAIN)
//   - sel_e            : source select for the ID instruction register
//   - sel_is_bubble()  : tells whether a select code loads an injected NOP
// ---------------------------------------------------------------------------
package if_id_ir_stage_pkg;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // Holds BR_BUBBLES, whose legal range is 0..15.
  localparam int unsigned REM_W = 4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SEL_IF  = 2'd0,
    SEL_NOP = 2'd1,
    SEL_BR  = 2'd2
  } sel_e;

  function automatic logic sel_is_bubble(input sel_e sel);
    return (sel == SEL_NOP);
  endfunction

endpackage : if_id_ir_stage_pkg

// File: rtl/if_id_ir_stage_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//
// Up-counter that sticks at all-ones instead of wrapping. Used for the
// bubble statistics of the IF/ID stage.
//
// Parameters:
//   W     : counter width
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : add one on this edge (ignored once saturated)
//   cnt   : current count (registered)
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Saturating increment: all-ones is terminal.
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] val);
    logic [W-1:0] res;
    if (&val) begin
      res = val;
    end else begin
      res = val + {{(W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (inc) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : sat_counter

// File: rtl/if_id_ir_stage.sv
// ---------------------------------------------------------------------------
// if_id_ir_stage
//
// Registered IF/ID instruction stage. Every rising edge loads the ID
// instruction register from exactly one source, chosen by priority:
//   flush > stall (hold) > branch taken > bubble drain > normal fetch.
// After a taken branch, a small RUN/DRAIN FSM injects BR_BUBBLES NOP slots
// before fetched words are accepted again. All outputs are registered, so
// there is no combinational input-to-output path.
//
// Parameters:
//   DATA_W     : instruction word width
//   NOP_WORD   : word injected as a bubble
//   BR_BUBBLES : NOP slots emitted after a taken branch (0..15)
//   STAT_W     : width of the saturating bubble statistics counter
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   if_instr     : fetched word
//   if_valid     : if_instr is valid this cycle
//   br_instr     : instruction to issue on a taken branch
//   br_taken     : branch resolved taken (one-cycle pulse)
//   flush        : kill ID contents and abort any bubble drain
//   stall        : hold ID register, FSM and statistics
//   id_instr     : registered instruction to the ID decoder
//   id_valid     : id_instr is a real or bubble slot to decode
//   id_is_bubble : id_instr is an injected NOP_WORD
//   drain_busy   : FSM is in DRAIN
//   bubble_cnt   : saturating count of edges that loaded a bubble
// ---------------------------------------------------------------------------
module if_id_ir_stage
  import if_id_ir_stage_pkg::*;
#(
  parameter int unsigned        DATA_W     = 32,
  parameter logic [DATA_W-1:0]  NOP_WORD   = DATA_W'(NOP_WORD_DEFAULT),
  parameter int unsigned        BR_BUBBLES = 1,
  parameter int unsigned        STAT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] if_instr,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] br_instr,
  input  logic              br_taken,
  input  logic              flush,
  input  logic              stall,
  output logic [DATA_W-1:0] id_instr,
  output logic              id_valid,
  output logic              id_is_bubble,
  output logic              drain_busy,
  output logic [STAT_W-1:0] bubble_cnt
);

  localparam logic [REM_W-1:0] BR_REM    = REM_W'(BR_BUBBLES);
  localparam logic             HAS_DRAIN = (BR_BUBBLES > 0);

  // FSM / counter state
  state_e             state_q, state_d;
  logic [REM_W-1:0]   rem_q,   rem_d;

  // ID register
  logic [DATA_W-1:0]  id_instr_q, id_instr_d;
  logic               id_valid_q, id_valid_d;
  logic               id_bub_q,   id_bub_d;

  // Decode results
  sel_e               sel;
  logic               load;
  logic               bub_inc;

  // -------------------------------------------------------------------------
  // Stage boundary: IF inputs -> select / next-state decode
  // -------------------------------------------------------------------------
  always_comb begin
    sel     = SEL_IF;
    load    = 1'b0;
    bub_inc = 1'b0;
    state_d = state_q;
    rem_d   = rem_q;

    if (flush) begin
      // Flush beats stall and drops any concurrent branch.
      load    = 1'b1;
      sel     = SEL_NOP;
      bub_inc = 1'b1;
      state_d = ST_RUN;
      rem_d   = '0;
    end else if (stall) begin
      // Full hold: a branch presented during a stall is lost and must be
      // re-presented by the hazard unit.
      load = 1'b0;
    end else if (br_taken) begin
      load = 1'b1;
      sel  = SEL_BR;
      // A branch arriving mid-drain reloads the count.
      if (HAS_DRAIN) begin
        state_d = ST_DRAIN;
        rem_d   = BR_REM;
      end else begin
        state_d = ST_RUN;
        rem_d   = '0;
      end
    end else if (state_q == ST_DRAIN) begin
      // Fetched word is discarded while draining.
      load    = 1'b1;
      sel     = SEL_NOP;
      bub_inc = 1'b1;
      rem_d   = rem_q - REM_W'(1);
      if (rem_q == REM_W'(1)) begin
        state_d = ST_RUN;
      end
    end else begin
      load = 1'b1;
      sel  = SEL_IF;
    end
  end

  always_comb begin
    id_instr_d = if_instr;
    id_valid_d = if_valid;
    unique case (sel)
      SEL_BR: begin
        id_instr_d = br_instr;
        id_valid_d = 1'b1;
      end
      SEL_NOP: begin
        id_instr_d = NOP_WORD;
        id_valid_d = 1'b1;
      end
      default: begin
        id_instr_d = if_instr;
        id_valid_d = if_valid;
      end
    endcase
    id_bub_d = sel_is_bubble(sel);
  end

  // -------------------------------------------------------------------------
  // Stage boundary: ID register and drain FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      rem_q      <= '0;
      id_instr_q <= NOP_WORD;
      id_valid_q <= 1'b0;
      id_bub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (load) begin
        id_instr_q <= id_instr_d;
        id_valid_q <= id_valid_d;
        id_bub_q   <= id_bub_d;
      end
    end
  end

  sat_counter #(
    .W (STAT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bub_inc),
    .cnt   (bubble_cnt)
  );

  assign id_instr     = id_instr_q;
  assign id_valid     = id_valid_q;
  assign id_is_bubble = id_bub_q;
  assign drain_busy   = (state_q == ST_DRAIN);

endmodule : if_id_ir_stage

// File: tb/tb_if_id_ir_stage.sv
module tb_if_id_ir_stage;

  localparam int          BRB = 2;
  localparam int          SW  = 4;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] if_instr = '0;
  logic        if_valid = 1'b0;
  logic [31:0] br_instr = '0;
  logic        br_taken = 1'b0;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        id_is_bubble;
  logic        drain_busy;
  logic [SW-1:0] bubble_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what ID should show, how many bubbles are still owed,
  // and the saturating statistic as a plain integer.
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_bub;
  int          m_pend;
  int          m_cnt;

  always #5 clk = ~clk;

  if_id_ir_stage #(
    .DATA_W     (32),
    .NOP_WORD   (NOP),
    .BR_BUBBLES (BRB),
    .STAT_W     (SW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_instr     (if_instr),
    .if_valid     (if_valid),
    .br_instr     (br_instr),
    .br_taken     (br_taken),
    .flush        (flush),
    .stall        (stall),
    .id_instr     (id_instr),
    .id_valid     (id_valid),
    .id_is_bubble (id_is_bubble),
    .drain_busy   (drain_busy),
    .bubble_cnt   (bubble_cnt)
  );

  logic [38:0] dut_vec;
  assign dut_vec = {id_instr, id_valid, id_is_bubble, drain_busy, bubble_cnt};

  function automatic logic [38:0] exp_vec();
    logic [SW-1:0] c;
    c = SW'(m_cnt);
    return {m_instr, m_valid, m_bub, (m_pend > 0), c};
  endfunction

  task automatic model_reset();
    m_instr = NOP;
    m_valid = 1'b0;
    m_bub   = 1'b0;
    m_pend  = 0;
    m_cnt   = 0;
  endtask

  task automatic add_bubble();
    m_instr = NOP;
    m_valid = 1'b1;
    m_bub   = 1'b1;
    if (m_cnt < (1 << SW) - 1) m_cnt = m_cnt + 1;
  endtask

  // Drive one cycle of inputs, take the edge, advance the model, and settle
  // 1 time unit past the edge for sampling.
  task automatic step(input logic fl, input logic st, input logic br,
                      input logic [31:0] bi, input logic [31:0] ii,
                      input logic iv);
    flush    = fl;
    stall    = st;
    br_taken = br;
    br_instr = bi;
    if_instr = ii;
    if_valid = iv;
    @(posedge clk);
    if (fl) begin
      add_bubble();
      m_pend = 0;
    end else if (st) begin
      // everything holds
    end else if (br) begin
      m_instr = bi;
      m_valid = 1'b1;
      m_bub   = 1'b0;
      m_pend  = BRB;
    end else if (m_pend > 0) begin
      add_bubble();
      m_pend = m_pend - 1;
    end else begin
      m_instr = ii;
      m_valid = iv;
      m_bub   = 1'b0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; stall = 1'b0; br_taken = 1'b0;
    if_valid = 1'b0; if_instr = '0; br_instr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_state: got %h required %h", dut_vec, exp_vec());
    end
    n_checks++;
    if (id_instr !== 32'h0 || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_id: got instr=%h valid=%b required 0/0", id_instr, id_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 32'h0, 32'h1111_0001, 1);
    n_checks++;
    if (id_instr !== 32'h1111_0001 || id_valid !== 1'b1 || id_is_bubble !== 1'b0) begin
      n_fail++;
      $display("FAIL first_fetch: got instr=%h valid=%b bub=%b required 11110001/1/0",
               id_instr, id_valid, id_is_bubble);
    end
  endtask

  task automatic test_branch();
    logic [31:0] seq [4];
    do_reset();
    step(0, 0, 0, 32'h0, 32'h2222_0000, 1);
    step(0, 0, 1, 32'hB000_0004, 32'h2222_0001, 1);
    seq[0] = id_instr;
    n_checks++;
    if (drain_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL br_busy0: got %b required 1", drain_busy);
    end
    step(0, 0, 0, 32'h0, 32'h3333_0003, 1);
    seq[1] = id_instr;
    n_checks++;
    if (drain_busy !== 1'b1 || id_is_bubble !== 1'b1) begin
      n_fail++;
      $display("FAIL br_busy1: got busy=%b bub=%b required 1/1", drain_busy, id_is_bubble);
    end
    step(0, 0, 0, 32'h0, 32'h3333_0003, 1);
    seq[2] = id_instr;
    n_checks++;
    if (drain_busy !== 1'b0 || id_is_bubble !== 1'b1) begin
      n_fail++;
      $display("FAIL br_busy2: got busy=%b bub=%b required 0/1", drain_busy, id_is_bubble);
    end
    step(0, 0, 0, 32'h0, 32'h3333_0003, 1);
    seq[3] = id_instr;
    n_checks++;
    if (seq[0] !== 32'hB000_0004 || seq[1] !== NOP || seq[2] !== NOP ||
        seq[3] !== 32'h3333_0003) begin
      n_fail++;
      $display("FAIL br_seq: got %h %h %h %h required b0000004 0 0 33330003",
               seq[0], seq[1], seq[2], seq[3]);
    end
    n_checks++;
    if (bubble_cnt !== SW'(2) || id_is_bubble !== 1'b0) begin
      n_fail++;
      $display("FAIL br_cnt: got cnt=%0d bub=%b required 2/0", bubble_cnt, id_is_bubble);
    end
  endtask

  task automatic test_stall_drain();
    do_reset();
    step(0, 0, 1, 32'hB000_0008, 32'h4444_0000, 1);
    step(0, 0, 0, 32'h0, 32'h4444_0001, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 32'h0, 32'h4444_0100 + i, 1);
      n_checks++;
      if (id_instr !== NOP || id_is_bubble !== 1'b1 || drain_busy !== 1'b1 ||
          bubble_cnt !== SW'(1)) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got instr=%h bub=%b busy=%b cnt=%0d required 0/1/1/1",
                 i, id_instr, id_is_bubble, drain_busy, bubble_cnt);
      end
    end
    step(0, 0, 0, 32'h0, 32'h4444_0002, 1);
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL stall_second_nop: got %h required %h", dut_vec, exp_vec());
    end
    step(0, 0, 0, 32'h0, 32'h4444_0003, 1);
    n_checks++;
    if (id_instr !== 32'h4444_0003 || bubble_cnt !== SW'(2) || drain_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_resume: got instr=%h cnt=%0d busy=%b required 44440003/2/0",
               id_instr, bubble_cnt, drain_busy);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(1, 0, 1, 32'hB000_00F0, 32'h5555_0000, 1);
    n_checks++;
    if (id_instr !== NOP || id_is_bubble !== 1'b1 || drain_busy !== 1'b0 ||
        bubble_cnt !== SW'(1)) begin
      n_fail++;
      $display("FAIL flush_br: got instr=%h bub=%b busy=%b cnt=%0d required 0/1/0/1",
               id_instr, id_is_bubble, drain_busy, bubble_cnt);
    end
    step(0, 0, 1, 32'hB000_00F4, 32'h5555_0001, 1);
    step(1, 1, 0, 32'h0, 32'h5555_0002, 1);
    n_checks++;
    if (id_instr !== NOP || id_is_bubble !== 1'b1 || drain_busy !== 1'b0 ||
        bubble_cnt !== SW'(2)) begin
      n_fail++;
      $display("FAIL flush_stall: got instr=%h bub=%b busy=%b cnt=%0d required 0/1/0/2",
               id_instr, id_is_bubble, drain_busy, bubble_cnt);
    end
    // Stall with a branch: the branch is dropped.
    step(0, 1, 1, 32'hB000_00F8, 32'h5555_0003, 1);
    step(0, 0, 0, 32'h0, 32'h5555_0004, 1);
    n_checks++;
    if (id_instr !== 32'h5555_0004 || drain_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_br_drop: got instr=%h busy=%b required 55550004/0",
               id_instr, drain_busy);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 32'h0, 32'h6666_0000 + i, 1);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL sat_step[%0d]: got %h required %h", i, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (bubble_cnt !== SW'(15)) begin
      n_fail++;
      $display("FAIL sat_final: got %0d required 15", bubble_cnt);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    step(0, 0, 1, 32'hB000_0010, 32'h7777_0000, 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (id_instr !== NOP || id_valid !== 1'b0 || id_is_bubble !== 1'b0 ||
        drain_busy !== 1'b0 || bubble_cnt !== SW'(0)) begin
      n_fail++;
      $display("FAIL async_reset: got %h required %h", dut_vec, exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 32'h0, 32'h7777_0010 + i, 1);
      n_checks++;
      if (id_instr !== 32'h7777_0010 + i || id_is_bubble !== 1'b0 || bubble_cnt !== SW'(0)) begin
        n_fail++;
        $display("FAIL post_reset[%0d]: got instr=%h bub=%b cnt=%0d", i, id_instr,
                 id_is_bubble, bubble_cnt);
      end
    end
  endtask

  task automatic test_random();
    logic fl, st, br, iv;
    logic [31:0] bi, ii;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      fl = ($urandom_range(0, 11) == 0);
      st = ($urandom_range(0, 4) == 0);
      br = ($urandom_range(0, 6) == 0);
      iv = ($urandom_range(0, 3) != 0);
      bi = $urandom;
      ii = $urandom;
      step(fl, st, br, bi, ii, iv);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h required %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_branch();
    test_stall_drain();
    test_simultaneous();
    test_saturation();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_if_id_ir_stage
